// File: rtl/uart_pkg.sv
// Shared types and constants for the GPIO UART transmit path.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  localparam int UART_DATA_BITS = 8;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/gpio_uart_tx_word_fifo.sv
// Circular word buffer with wrapping pointers and an explicit occupancy count.
// Push while full and pop while empty are ignored, so callers may drive them freely.
module word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt_q;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign dout    = mem[rd_ptr];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Pointer and occupancy bookkeeping; simultaneous push/pop leaves the count unchanged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage array; contents are only meaningful while counted, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/gpio_uart_tx.sv
// Streams 32-bit GPIO words off-chip as four 8N1 UART bytes, least-significant byte first.
// tx is registered from the current state, so the line lags the FSM by one clock.
module gpio_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_valid,
  input  logic [31:0] wr_data,
  output logic        wr_ready,
  output logic        tx,
  output logic        busy,
  output logic        overflow
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  uart_state_t       state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [1:0]        byte_q, byte_d;
  logic [31:0]       shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              overflow_q;

  logic              fifo_pop;
  logic [31:0]       fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              baud_done;

  word_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wr_valid && wr_ready),
    .pop   (fifo_pop),
    .din   (wr_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign wr_ready  = !fifo_full;
  assign baud_done = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
  assign tx        = tx_q;
  assign busy      = (state_q != IDLE) || (fifo_count != '0);
  assign overflow  = overflow_q;

  // Next-state, counter, shift-register and line-level decode.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q + 1'b1;
    bit_d    = bit_q;
    byte_d   = byte_q;
    shift_d  = shift_q;
    tx_d     = 1'b1;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          byte_d   = '0;
          state_d  = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (baud_done) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        tx_d = shift_q[bit_q];
        if (baud_done) begin
          baud_d = '0;
          if (bit_q == 3'(UART_DATA_BITS - 1)) state_d = STOP;
          else                                 bit_d   = bit_q + 3'd1;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (baud_done) begin
          baud_d = '0;
          if (byte_q != 2'(BYTES_PER_WORD - 1)) begin
            byte_d  = byte_q + 2'd1;
            shift_d = shift_q >> UART_DATA_BITS;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers; reset forces IDLE and drives the line high on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      byte_q     <= '0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      tx_q    <= tx_d;
      if (wr_valid && !wr_ready) overflow_q <= 1'b1;
    end
  end

  // Word shift register is pure data and is always reloaded from the queue before use.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

endmodule

// File: tb/tb_gpio_uart_tx.sv
// Directed bench for gpio_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_gpio_uart_tx;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_valid;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic        tx;
  logic        busy;
  logic        overflow;

  int checks   = 0;
  int failures = 0;

  gpio_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .tx       (tx),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]     word;
    logic [3:0][7:0] exp_bytes;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Wait (at falling edges) until tx is low, bounded by limit cycles.
  task automatic wait_low(input int limit);
    int n;
    n = 0;
    while (tx !== 1'b0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("wait_tx_low", {31'd0, tx === 1'b0}, 32'd1);
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle", {31'd0, busy === 1'b0}, 32'd1);
  endtask

  // Receive one 4-byte word; sampling on the first clk of every bit period.
  // Returns positioned at the first clk of the last stop bit.
  task automatic recv_word(output logic [31:0] w);
    w = '0;
    wait_low(800);
    for (int by = 0; by < 4; by++) begin
      chk("frame_start", {31'd0, tx}, 32'd0);
      repeat (CPB) @(negedge clk);
      for (int b = 0; b < 8; b++) begin
        w[8*by+b] = tx;
        repeat (CPB) @(negedge clk);
      end
      chk("frame_stop", {31'd0, tx}, 32'd1);
      if (by < 3) repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic write_word(input logic [31:0] w);
    wr_valid = 1'b1;
    wr_data  = w;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  vec_t        vecs [5];
  logic [31:0] got;
  logic [31:0] ov_words [6];
  logic [31:0] ov_got [5];
  int          lows;

  initial begin
    vecs[0] = '{32'hA5C30F81, {8'hA5, 8'hC3, 8'h0F, 8'h81}};
    vecs[1] = '{32'h00000000, {8'h00, 8'h00, 8'h00, 8'h00}};
    vecs[2] = '{32'hFFFFFFFF, {8'hFF, 8'hFF, 8'hFF, 8'hFF}};
    vecs[3] = '{32'h12345678, {8'h12, 8'h34, 8'h56, 8'h78}};
    vecs[4] = '{32'h80000001, {8'h80, 8'h00, 8'h00, 8'h01}};
    ov_words = '{32'h11111111, 32'h22222222, 32'h33333333,
                 32'h44444444, 32'h55555555, 32'h66666666};

    // 1. reset and idle
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    wr_data  = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    lows = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    chk("idle_tx_high", lows, 0);

    // 2. table of single words: latency, byte order, framing, busy release
    for (int v = 0; v < 5; v++) begin
      write_word(vecs[v].word);
      chk("lat_tx_n0", {31'd0, tx}, 32'd1);
      @(negedge clk);
      chk("lat_tx_n1", {31'd0, tx}, 32'd1);
      chk("lat_busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
      chk("lat_tx_n2", {31'd0, tx}, 32'd0);
      recv_word(got);
      for (int by = 0; by < 4; by++)
        chk($sformatf("vec%0d_byte%0d", v, by), {24'd0, got[8*by +: 8]}, {24'd0, vecs[v].exp_bytes[by]});
      repeat (2) @(negedge clk);
      chk("busy_at_160", {31'd0, busy}, 32'd1);
      @(negedge clk);
      chk("busy_at_161", {31'd0, busy}, 32'd0);
      chk("tx_after_word", {31'd0, tx}, 32'd1);
    end

    // 3. overflow: six writes on consecutive clocks, receiver running alongside
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          wr_valid = 1'b1;
          wr_data  = ov_words[i];
          chk($sformatf("ovf_ready%0d", i), {31'd0, wr_ready}, {31'd0, i < 5});
          @(negedge clk);
        end
        wr_valid = 1'b0;
        chk("ovf_flag_set", {31'd0, overflow}, 32'd1);
      end
      begin
        for (int i = 0; i < 5; i++) recv_word(ov_got[i]);
      end
    join
    for (int i = 0; i < 5; i++)
      chk($sformatf("ovf_word%0d", i), ov_got[i], ov_words[i]);
    wait_idle(400);
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);
    chk("ovf_ready_back", {31'd0, wr_ready}, 32'd1);

    // 4. reset mid-frame during byte 2 start bit, two words queued
    write_word(32'hDEADBEEF);
    wait_low(10);
    for (int n = 0; n < 80; n++) begin
      wr_valid = (n == 5) || (n == 6);
      wr_data  = (n == 5) ? 32'hCAFEF00D : 32'h0BADC0DE;
      @(negedge clk);
    end
    wr_valid = 1'b0;
    chk("mid_pre_rst_tx", {31'd0, tx}, 32'd0);
    chk("mid_pre_rst_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_tx", {31'd0, tx}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_busy", {31'd0, busy}, 32'd0);
    chk("mid_overflow_clr", {31'd0, overflow}, 32'd0);
    chk("mid_wr_ready", {31'd0, wr_ready}, 32'd1);
    lows = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    chk("mid_no_restart", lows, 0);

    // 5. back-to-back: word B written during word A's byte 3
    write_word(32'h0F0F0F0F);
    wait_low(10);
    for (int n = 0; n < 161; n++) begin
      wr_valid = (n == 125);
      wr_data  = 32'hF00DFACE;
      if (n == 156 || n == 159) chk("b2b_stop", {31'd0, tx}, 32'd1);
      if (n == 160) chk("b2b_gap", {31'd0, tx}, 32'd1);
      @(negedge clk);
    end
    wr_valid = 1'b0;
    chk("b2b_start", {31'd0, tx}, 32'd0);
    recv_word(got);
    chk("b2b_word", got, 32'hF00DFACE);
    wait_idle(50);

    // 6. bit timing across a three-word burst; each word re-anchors after the pop gap
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          wr_valid = 1'b1;
          wr_data  = 32'h55555555;
          @(negedge clk);
        end
        wr_valid = 1'b0;
      end
      begin
        int   viol;
        int   trans;
        logic prev;
        viol  = 0;
        trans = 0;
        wait_low(20);
        prev = tx;
        for (int t = 1; t < 3 * 161 + 20; t++) begin
          @(negedge clk);
          if (tx !== prev) begin
            trans++;
            if (((t % 161) % CPB) != 0) viol++;
          end
          prev = tx;
        end
        chk("timing_violations", viol, 0);
        chk("timing_transitions", trans, 119);
      end
    join

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
